// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame constants and helper functions
// used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_rx_state_t;

    localparam int          UART_FRAME_BITS     = 11;
    localparam logic [15:0] UART_PRESCALE_MIN   = 16'd4;
    localparam int          UART_MAX_DATA_WIDTH = 16;

    // Even parity bit: XOR of all data bits (zero-extend narrower words).
    function automatic logic uart_parity(input logic [UART_MAX_DATA_WIDTH-1:0] data);
        return ^data;
    endfunction

    function automatic logic uart_majority(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line (both flops reset high) with a
// registered falling-edge pulse aligned to the synchronized output.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rxd,
    output logic line,
    output logic fall
);

    logic meta;

    // Synchronizer chain; the edge pulse is registered in step with 'line'.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            line <= 1'b1;
            fall <= 1'b0;
        end else begin
            meta <= rxd;
            line <= meta;
            fall <= line & ~meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, DATA_WIDTH data bits LSB first, even parity, stop.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority bit sampling (+1 cycle latency).
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rxd,
    input  logic [15:0]           prescale,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun_err,
    output logic                  busy
);

    localparam int             CW       = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_INIT = CW'(DATA_WIDTH);

    uart_rx_state_t        state;
    logic [15:0]           timer;
    logic [15:0]           p;
    logic [15:0]           pre;
    logic [CW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift;
    logic                  par_bad;
    logic                  line;
    logic                  fall;
    logic                  tick;
    logic                  act;
    logic                  bit_val;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .rxd  (rxd),
        .line (line),
        .fall (fall)
    );

    assign pre  = (prescale < UART_PRESCALE_MIN) ? UART_PRESCALE_MIN : prescale;
    assign tick = (state != IDLE) && (timer == 16'd0);

`ifdef UART_RX_MAJORITY_EN
    logic line_d1;
    logic line_d2;
    logic tick_d;

    // Keep the two previous line samples so the vote is available the cycle after tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_d1 <= 1'b1;
            line_d2 <= 1'b1;
            tick_d  <= 1'b0;
        end else begin
            line_d1 <= line;
            line_d2 <= line_d1;
            tick_d  <= tick;
        end
    end

    assign act     = tick_d;
    assign bit_val = uart_majority(line_d2, line_d1, line);
`else
    assign act     = tick;
    assign bit_val = line;
`endif

    // Frame FSM, bit timer and output registers; the timer grid is fixed at
    // tick so a delayed (majority) decision never shifts later sample points.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= 16'd0;
            p           <= 16'd0;
            bit_cnt     <= {CW{1'b0}};
            shift       <= {DATA_WIDTH{1'b0}};
            par_bad     <= 1'b0;
            rx_data     <= {DATA_WIDTH{1'b0}};
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (state != IDLE) begin
                timer <= (timer == 16'd0) ? (p - 16'd1) : (timer - 16'd1);
            end
            case (state)
                IDLE: begin
                    if (fall) begin
                        state <= START;
                        p     <= pre;
                        timer <= {1'b0, pre[15:1]} - 16'd1;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (act) begin
                        if (bit_val) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_cnt <= CNT_INIT;
                        end
                    end
                end
                DATA: begin
                    if (act) begin
                        shift   <= {bit_val, shift[DATA_WIDTH-1:1]};
                        bit_cnt <= bit_cnt - CNT_ONE;
                        if (bit_cnt == CNT_ONE) begin
                            state <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (act) begin
                        par_bad <= bit_val ^ uart_parity(UART_MAX_DATA_WIDTH'(shift));
                        state   <= STOP;
                    end
                end
                STOP: begin
                    if (act) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        // A word accepted this very cycle frees the holding register.
                        if (!rx_valid || rx_ready) begin
                            rx_data    <= shift;
                            parity_err <= par_bad;
                            frame_err  <= ~bit_val;
                            rx_valid   <= 1'b1;
                        end else begin
                            overrun_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: clean, parity, framing/break,
// false start, overrun, reset mid-frame and prescale clamping.
module tb_uart_rx;

`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    localparam int LAT16 = 171 + MAJ;
    localparam int LAT4  = 45 + MAJ;

    logic        clk;
    logic        rst;
    logic        rxd;
    logic [15:0] prescale;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        parity_err;
    logic        frame_err;
    logic        overrun_err;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rv_rises = 0;
    int rv_cyc = 0;
    int bz_rises = 0;
    int bz_rise_cyc = 0;
    int bz_fall_cyc = 0;
    int ovr_cnt = 0;
    int ovr_cyc = 0;
    int snap_rv = 0;
    int snap_bz = 0;
    int snap_ovr = 0;
    logic rv_q = 1'b0;
    logic bz_q = 1'b0;

    uart_rx #(.DATA_WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .rxd         (rxd),
        .prescale    (prescale),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor sampled on the falling edge.
    always @(negedge clk) begin
        rv_q <= rx_valid;
        bz_q <= busy;
        if (rx_valid && !rv_q) begin
            rv_rises <= rv_rises + 1;
            rv_cyc   <= cyc;
        end
        if (busy && !bz_q) begin
            bz_rises    <= bz_rises + 1;
            bz_rise_cyc <= cyc;
        end
        if (!busy && bz_q) bz_fall_cyc <= cyc;
        if (overrun_err) begin
            ovr_cnt <= ovr_cnt + 1;
            ovr_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                              input int blen);
        start_cyc = cyc;
        rxd = 1'b0;
        repeat (blen) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            repeat (blen) @(negedge clk);
        end
        rxd = par;
        repeat (blen) @(negedge clk);
        rxd = stop;
        repeat (blen) @(negedge clk);
    endtask

    task automatic accept();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rxd = 1'b1;
        rx_ready = 1'b0;
        prescale = 16'd16;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_data", 32'(rx_data), 32'h0);
        chk("reset_valid", 32'(rx_valid), 32'h0);
        chk("reset_perr", 32'(parity_err), 32'h0);
        chk("reset_ferr", 32'(frame_err), 32'h0);
        chk("reset_ovr", 32'(overrun_err), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);

        // Clean frame 0xA5 (parity 0) with latency checks.
        send_frame(8'hA5, 1'b0, 1'b1, 16);
        repeat (4) @(negedge clk);
        chk("clean_data", 32'(rx_data), 32'hA5);
        chk("clean_valid", 32'(rx_valid), 32'h1);
        chk("clean_perr", 32'(parity_err), 32'h0);
        chk("clean_ferr", 32'(frame_err), 32'h0);
        chk("start_latency", 32'(bz_rise_cyc - start_cyc), 32'd3);
        chk("valid_latency", 32'(rv_cyc - start_cyc), 32'(LAT16));
        chk("busy_fall_latency", 32'(bz_fall_cyc - start_cyc), 32'(LAT16));
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk("clean_cleared", 32'(rx_valid), 32'h0);

        // Parity error: 0x3C has even parity 0, sent as 1.
        repeat (32) @(negedge clk);
        send_frame(8'h3C, 1'b1, 1'b1, 16);
        repeat (4) @(negedge clk);
        chk("par_data", 32'(rx_data), 32'h3C);
        chk("par_valid", 32'(rx_valid), 32'h1);
        chk("par_perr", 32'(parity_err), 32'h1);
        chk("par_ferr", 32'(frame_err), 32'h0);
        accept();

        // Framing error followed by a 40-bit break.
        repeat (32) @(negedge clk);
        snap_rv = rv_rises;
        snap_bz = bz_rises;
        send_frame(8'h81, 1'b0, 1'b0, 16);
        repeat (4) @(negedge clk);
        chk("frm_data", 32'(rx_data), 32'h81);
        chk("frm_valid", 32'(rx_valid), 32'h1);
        chk("frm_ferr", 32'(frame_err), 32'h1);
        chk("frm_perr", 32'(parity_err), 32'h0);
        accept();
        repeat (640) @(negedge clk);
        chk("break_words", 32'(rv_rises - snap_rv), 32'd1);
        chk("break_busy", 32'(busy), 32'h0);
        chk("break_starts", 32'(bz_rises - snap_bz), 32'd1);
        rxd = 1'b1;
        repeat (32) @(negedge clk);
        chk("break_release_words", 32'(rv_rises - snap_rv), 32'd1);
        chk("break_release_valid", 32'(rx_valid), 32'h0);

        // False start: 5-cycle glitch.
        snap_rv = rv_rises;
        snap_bz = bz_rises;
        rxd = 1'b0;
        repeat (5) @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_busy_pulse", 32'(bz_rises - snap_bz), 32'd1);
        chk("glitch_busy_idle", 32'(busy), 32'h0);
        chk("glitch_no_word", 32'(rv_rises - snap_rv), 32'd0);
        chk("glitch_valid", 32'(rx_valid), 32'h0);

        // Overrun: two back-to-back frames with rx_ready low.
        snap_ovr = ovr_cnt;
        send_frame(8'h11, 1'b0, 1'b1, 16);
        send_frame(8'h22, 1'b0, 1'b1, 16);
        repeat (4) @(negedge clk);
        chk("ovr_data_held", 32'(rx_data), 32'h11);
        chk("ovr_valid", 32'(rx_valid), 32'h1);
        chk("ovr_pulses", 32'(ovr_cnt - snap_ovr), 32'd1);
        chk("ovr_timing", 32'(ovr_cyc - start_cyc), 32'(LAT16));
        chk("ovr_perr", 32'(parity_err), 32'h0);
        chk("ovr_ferr", 32'(frame_err), 32'h0);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk("ovr_cleared", 32'(rx_valid), 32'h0);

        // Reset during data bit 3 of 0x5A, then a clean 0x5A.
        repeat (32) @(negedge clk);
        rxd = 1'b0;
        repeat (16) @(negedge clk);
        rxd = 1'b0;
        repeat (16) @(negedge clk);
        rxd = 1'b1;
        repeat (16) @(negedge clk);
        rxd = 1'b0;
        repeat (16) @(negedge clk);
        rxd = 1'b1;
        repeat (8) @(negedge clk);
        chk("mid_frame_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_data", 32'(rx_data), 32'h0);
        chk("rst_mid_valid", 32'(rx_valid), 32'h0);
        chk("rst_mid_busy", 32'(busy), 32'h0);
        chk("rst_mid_perr", 32'(parity_err), 32'h0);
        chk("rst_mid_ferr", 32'(frame_err), 32'h0);
        chk("rst_mid_ovr", 32'(overrun_err), 32'h0);
        rst = 1'b0;
        repeat (32) @(negedge clk);
        send_frame(8'h5A, 1'b0, 1'b1, 16);
        repeat (4) @(negedge clk);
        chk("after_rst_data", 32'(rx_data), 32'h5A);
        chk("after_rst_valid", 32'(rx_valid), 32'h1);
        chk("after_rst_perr", 32'(parity_err), 32'h0);
        chk("after_rst_ferr", 32'(frame_err), 32'h0);
        chk("after_rst_latency", 32'(rv_cyc - start_cyc), 32'(LAT16));
        accept();

        // Prescale below the minimum is treated as 4.
        prescale = 16'd2;
        repeat (16) @(negedge clk);
        send_frame(8'h96, 1'b0, 1'b1, 4);
        repeat (8) @(negedge clk);
        chk("p4_data", 32'(rx_data), 32'h96);
        chk("p4_valid", 32'(rx_valid), 32'h1);
        chk("p4_perr", 32'(parity_err), 32'h0);
        chk("p4_latency", 32'(rv_cyc - start_cyc), 32'(LAT4));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
